map_access_arbiter: RTL and testbench

- Shares the dual-port tile-map RAM (30 rows x 40 tiles, 4-bit tile code per tile, 160-bit row word) between the VGA renderer and two game-logic clients (client 0 = pacman, client 1 = ghost/collision).
- VGA always owns the read port when busy.
- Game clients get tile reads and tile read-modify-writes (e.g. pellet eaten -> empty) via req/ack, granted round-robin.
- Sits between the game FSMs and the map RAM, alongside the VGA controller.

---
 rtl/map_access_arbiter_pkg.sv | 37 +++
 rtl/map_access_arbiter_if.sv | 24 ++
 rtl/map_access_arbiter_rr_arbiter2.sv | 27 ++
 rtl/map_access_arbiter.sv | 173 +++++++++++++++++
 tb/tb_map_access_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/map_access_arbiter_pkg.sv
// Shared widths, tile/state enums and the row-word nibble insert helper
// for the tile-map access arbiter.
package map_pkg;

  localparam int unsigned ROW_W    = 5;
  localparam int unsigned COL_W    = 6;
  localparam int unsigned TILE_W   = 4;
  localparam int unsigned WORD_MAX = TILE_W << COL_W;

  typedef enum logic [3:0] {
    EMPTY  = 4'd0,
    WALL   = 4'd1,
    PELLET = 4'd2,
    POWER  = 4'd3
  } tile_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WRITE,
    DONE
  } arb_state_t;

  // Works on the widest possible row word; callers keep the low 4*COLS bits.
  function automatic logic [WORD_MAX-1:0] tile_insert(
    input logic [WORD_MAX-1:0] word,
    input logic [COL_W-1:0]    col,
    input logic [TILE_W-1:0]   code
  );
    logic [WORD_MAX-1:0] w;
    w = word;
    w[{col, 2'b00} +: TILE_W] = code;
    return w;
  endfunction

endpackage

// File: rtl/map_access_arbiter_if.sv
// Two-client tile request/ack bus between the game FSMs and the map arbiter.
// Client fields are packed {c1, c0}.
interface map_access_arbiter_if;

  logic [1:0]  req;
  logic [1:0]  we;
  logic [9:0]  row;
  logic [11:0] col;
  logic [7:0]  wdata;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        err;

  modport master (
    output req, we, row, col, wdata,
    input  ack, rdata, err
  );

  modport slave (
    input  req, we, row, col, wdata,
    output ack, rdata, err
  );

endinterface

// File: rtl/map_access_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; on a tie the client that did not win last time
// is chosen. last_grant resets to 1 so client 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic       o_valid,
  output logic       o_grant
);

  logic r_last_grant;

  always_comb begin
    o_valid = |i_req;
    o_grant = (i_req == 2'b11) ? ~r_last_grant : i_req[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (i_accept && o_valid) begin
      r_last_grant <= o_grant;
    end
  end

endmodule

// File: rtl/map_access_arbiter.sv
// Shares the tile-map RAM read port between VGA (priority) and two game
// clients doing tile reads / read-modify-writes. Optional PELLET_COUNT_EN
// adds a pellet counter (pellets_left, level_clear).
module map_access_arbiter
  import map_pkg::*;
#(
  parameter int unsigned ROWS        = 30,
  parameter int unsigned COLS        = 40,
  parameter int unsigned RD_LAT      = 1,
  parameter logic [3:0]  PELLET_CODE = 4'd2,
  parameter logic [9:0]  PELLET_INIT = 10'd0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              vga_busy,
  input  logic [4:0]        vga_row,
  map_access_arbiter_if.slave bus,
  output logic [4:0]        map_rdaddress,
  output logic              map_rden,
  output logic [4:0]        map_wraddress,
  output logic              map_wren,
  output logic [4*COLS-1:0] map_data,
  input  logic [4*COLS-1:0] map_q
`ifdef PELLET_COUNT_EN
  ,
  output logic [9:0]        pellets_left,
  output logic              level_clear
`endif
);

  localparam logic [5:0] ROWS_L = 6'(ROWS);
  localparam logic [6:0] COLS_L = 7'(COLS);

  arb_state_t          r_state;
  logic                r_gnt;
  logic [4:0]          r_row;
  logic [5:0]          r_col;
  logic                r_we;
  logic [3:0]          r_wdata;
  logic [3:0]          r_tile;
  logic [1:0]          r_cnt;
  logic [1:0]          r_ack;
  logic [7:0]          r_rdata;
  logic                r_err;

  logic                w_gnt_valid;
  logic                w_gnt;
  logic [4:0]          w_req_row;
  logic [5:0]          w_req_col;
  logic                w_oor;
  logic [WORD_MAX-1:0] w_q_ext;
  logic [3:0]          w_q_tile;
  logic [WORD_MAX-1:0] w_ins;
  logic                w_unused_cfg;

  rr_arbiter2 u_rr (
    .clk      (CLOCK_50),
    .reset    (reset),
    .i_req    (bus.req),
    .i_accept (r_state == IDLE),
    .o_valid  (w_gnt_valid),
    .o_grant  (w_gnt)
  );

  always_comb begin
    w_req_row = w_gnt ? bus.row[9:5]  : bus.row[4:0];
    w_req_col = w_gnt ? bus.col[11:6] : bus.col[5:0];
    w_oor     = ({1'b0, w_req_row} >= ROWS_L) || ({1'b0, w_req_col} >= COLS_L);
    w_q_ext   = '0;
    w_q_ext[4*COLS-1:0] = map_q;
    w_q_tile  = w_q_ext[{r_col, 2'b00} +: 4];
    w_ins     = tile_insert(w_q_ext, r_col, r_wdata);
  end

  assign map_rdaddress = vga_busy ? vga_row : r_row;
  assign map_rden      = 1'b1;
  assign bus.ack       = r_ack;
  assign bus.rdata     = r_rdata;
  assign bus.err       = r_err;
  assign w_unused_cfg  = ^{PELLET_CODE, PELLET_INIT, w_ins};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state       <= IDLE;
      r_gnt         <= 1'b0;
      r_row         <= '0;
      r_col         <= '0;
      r_we          <= 1'b0;
      r_wdata       <= '0;
      r_tile        <= '0;
      r_cnt         <= '0;
      r_ack         <= '0;
      r_err         <= 1'b0;
      r_rdata       <= '0;
      map_wren      <= 1'b0;
      map_wraddress <= '0;
      map_data      <= '0;
    end else begin
      r_ack    <= '0;
      r_err    <= 1'b0;
      map_wren <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_gnt   <= w_gnt;
            r_row   <= w_req_row;
            r_col   <= w_req_col;
            r_we    <= bus.we[w_gnt];
            r_wdata <= w_gnt ? bus.wdata[7:4] : bus.wdata[3:0];
            if (w_oor) begin
              r_state <= DONE;
              r_ack[w_gnt] <= 1'b1;
              r_err   <= 1'b1;
              r_rdata[{w_gnt, 2'b00} +: 4] <= '0;
            end else begin
              r_state <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          if (!vga_busy) begin
            r_state <= RD_WAIT;
            r_cnt   <= 2'(RD_LAT);
          end
        end
        RD_WAIT: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) begin
            r_tile <= w_q_tile;
            if (r_we) begin
              r_state       <= WRITE;
              map_wren      <= 1'b1;
              map_wraddress <= r_row;
              map_data      <= w_ins[4*COLS-1:0];
            end else begin
              r_state <= DONE;
              r_ack[r_gnt] <= 1'b1;
              r_rdata[{r_gnt, 2'b00} +: 4] <= w_q_tile;
            end
          end
        end
        WRITE: begin
          r_state <= DONE;
          r_ack[r_gnt] <= 1'b1;
          r_rdata[{r_gnt, 2'b00} +: 4] <= r_tile;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef PELLET_COUNT_EN
  logic [9:0] r_pellets;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_pellets <= PELLET_INIT;
    end else if (r_state == WRITE && r_tile == PELLET_CODE &&
                 r_wdata != PELLET_CODE && r_pellets != '0) begin
      r_pellets <= r_pellets - 10'd1;
    end
  end

  assign pellets_left = r_pellets;
  assign level_clear  = (r_pellets == '0);
`endif

endmodule

// File: tb/tb_map_access_arbiter.sv
// Randomised self-checking bench: tile-level reference model plus a simple
// behavioural map RAM with one cycle read latency.
module tb_map_access_arbiter;
  import map_pkg::*;

  localparam int ROWS = 30;
  localparam int COLS = 40;

  logic         CLOCK_50 = 1'b0;
  logic         reset    = 1'b1;
  logic         vga_busy = 1'b0;
  logic [4:0]   vga_row  = '0;
  logic [4:0]   map_rdaddress, map_wraddress;
  logic         map_rden, map_wren;
  logic [159:0] map_data;
  logic [159:0] map_q;
`ifdef PELLET_COUNT_EN
  logic [9:0]   pellets_left;
  logic         level_clear;
`endif

  map_access_arbiter_if bus ();

  map_access_arbiter #(.ROWS(ROWS), .COLS(COLS), .RD_LAT(1)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .vga_busy      (vga_busy),
    .vga_row       (vga_row),
    .bus           (bus),
    .map_rdaddress (map_rdaddress),
    .map_rden      (map_rden),
    .map_wraddress (map_wraddress),
    .map_wren      (map_wren),
    .map_data      (map_data),
    .map_q         (map_q)
`ifdef PELLET_COUNT_EN
    ,
    .pellets_left  (pellets_left),
    .level_clear   (level_clear)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [159:0] mem [ROWS];
  logic         ld_en = 1'b0;
  logic [4:0]   ld_row = '0;
  logic [159:0] ld_word = '0;

  always @(posedge CLOCK_50) begin
    map_q <= (int'(map_rdaddress) < ROWS) ? mem[map_rdaddress] : '0;
    if (ld_en) mem[ld_row] <= ld_word;
    else if (map_wren && int'(map_wraddress) < ROWS) mem[map_wraddress] <= map_data;
  end

  logic [3:0] ref_t [ROWS][COLS];
  logic [3:0] exp_rd [2];
  int checks = 0;
  int errors = 0;

  task automatic load_row(input int r);
    for (int c = 0; c < COLS; c++) ld_word[4*c +: 4] = ref_t[r][c];
    ld_row = 5'(r);
    ld_en  = 1'b1;
    @(negedge CLOCK_50);
    ld_en  = 1'b0;
  endtask

  function automatic int row_diffs(input int r);
    int n = 0;
    for (int c = 0; c < COLS; c++)
      if (mem[r][4*c +: 4] !== ref_t[r][c]) n++;
    return n;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    vga_busy = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // Reference: error if outside the map, otherwise old tile returned and
  // written tile replaces it; latency from the documented cycle counts.
  task automatic model_txn(input int c, input bit w, input logic [4:0] r,
                           input logic [5:0] cl, input logic [3:0] d, input int busy,
                           output int lat, output logic [3:0] rd, output logic e);
    e = (int'(r) >= ROWS) || (int'(cl) >= COLS);
    if (e) begin
      lat = 1;
      rd  = '0;
    end else begin
      rd  = ref_t[r][cl];
      lat = (w ? 4 : 3) + busy;
      if (w) ref_t[r][cl] = d;
    end
    exp_rd[c] = rd;
  endtask

  task automatic set_client(input int c, input bit w, input logic [4:0] r,
                            input logic [5:0] cl, input logic [3:0] d);
    if (c == 0) begin
      bus.row[4:0] = r; bus.col[5:0] = cl; bus.wdata[3:0] = d;
    end else begin
      bus.row[9:5] = r; bus.col[11:6] = cl; bus.wdata[7:4] = d;
    end
    bus.we[c] = w;
  endtask

  task automatic run_txn(input int c, input bit w, input logic [4:0] r,
                         input logic [5:0] cl, input logic [3:0] d, input int busy,
                         output int lat, output logic [3:0] rd, output logic e,
                         output int wr, output int bad);
    lat = -1; rd = '0; e = 1'b0; wr = 0; bad = 0;
    set_client(c, w, r, cl, d);
    bus.req[c] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLOCK_50);
      if (map_wren) begin
        wr++;
        if (map_wraddress !== r) bad++;
      end
      if (vga_busy && map_rdaddress !== vga_row) bad++;
      if (bus.ack[c]) begin
        lat = k;
        rd  = (c == 1) ? bus.rdata[7:4] : bus.rdata[3:0];
        e   = bus.err;
        break;
      end
      vga_busy = (k <= busy);
      vga_row  = 5'($urandom_range(0, 29));
    end
    bus.req[c] = 1'b0;
    vga_busy = 1'b0;
    @(negedge CLOCK_50);
    if (bus.ack !== 2'b00 || bus.err !== 1'b0 || map_wren !== 1'b0) bad++;
  endtask

  task automatic test_reset();
    checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", bus.ack); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", bus.rdata); end
    checks++; if (map_wren !== 1'b0 || map_wraddress !== 5'd0) begin errors++; $display("FAIL reset_wport: got wren=%b addr=%0d want 0/0", map_wren, map_wraddress); end
    checks++; if (map_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", map_data); end
    checks++; if (map_rden !== 1'b1) begin errors++; $display("FAIL rden: got %b want 1", map_rden); end
    vga_row = 5'd17; vga_busy = 1'b1; #1;
    checks++; if (map_rdaddress !== 5'd17) begin errors++; $display("FAIL rd_mux: got %0d want 17", map_rdaddress); end
    vga_busy = 1'b0;
`ifdef PELLET_COUNT_EN
    checks++; if (pellets_left !== 10'd0 || level_clear !== 1'b1) begin errors++; $display("FAIL reset_pellets: got %0d/%b want 0/1", pellets_left, level_clear); end
`endif
    @(negedge CLOCK_50);
  endtask

  task automatic check_txn(input string nm, input int c, input bit w, input logic [4:0] r,
                           input logic [5:0] cl, input logic [3:0] d, input int busy);
    int lat, elat, wr, bad;
    logic [3:0] rd, erd;
    logic e, ee;
    model_txn(c, w, r, cl, d, busy, elat, erd, ee);
    run_txn(c, w, r, cl, d, busy, lat, rd, e, wr, bad);
    checks++; if (lat !== elat) begin errors++; $display("FAIL %s_lat: got %0d want %0d", nm, lat, elat); end
    checks++; if (rd !== erd || e !== ee) begin errors++; $display("FAIL %s_data: got tile=%0d err=%b want tile=%0d err=%b", nm, rd, e, erd, ee); end
    checks++; if (wr !== ((w && !ee) ? 1 : 0) || bad !== 0) begin errors++; $display("FAIL %s_ports: got wren_pulses=%0d bad=%0d want %0d/0", nm, wr, bad, (w && !ee) ? 1 : 0); end
    checks++; if (bus.rdata !== {exp_rd[1], exp_rd[0]}) begin errors++; $display("FAIL %s_hold: got %h want %h", nm, bus.rdata, {exp_rd[1], exp_rd[0]}); end
    if (!ee) begin
      checks++; if (row_diffs(int'(r)) !== 0) begin errors++; $display("FAIL %s_row: got %0d bad tiles in row %0d want 0", nm, row_diffs(int'(r)), r); end
    end
  endtask

  task automatic test_read();
    ref_t[3][5] = 4'd1; load_row(3);
    check_txn("read", 0, 1'b0, 5'd3, 6'd5, 4'd0, 0);
  endtask

  task automatic test_write();
    ref_t[7][39] = 4'd2; load_row(7);
    check_txn("write", 1, 1'b1, 5'd7, 6'd39, 4'd0, 0);
  endtask

  task automatic test_vga_preempt();
    check_txn("vga", 0, 1'b0, 5'($urandom_range(0, 29)), 6'($urandom_range(0, 39)), 4'd0, 5);
    check_txn("vga_wr", 1, 1'b1, 5'($urandom_range(0, 29)), 6'($urandom_range(0, 39)), 4'($urandom), 2);
  endtask

  task automatic test_out_of_range();
    check_txn("oor_row", 0, 1'b0, 5'd30, 6'd5, 4'd0, 0);
    check_txn("oor_col", 0, 1'b1, 5'd4, 6'd40, 4'd3, 0);
    checks++; if (row_diffs(4) !== 0) begin errors++; $display("FAIL oor_nowrite: got %0d bad tiles want 0", row_diffs(4)); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      check_txn("rand", int'($urandom_range(0, 1)), 1'($urandom), 5'($urandom_range(0, 31)),
                6'($urandom_range(0, 47)), 4'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic test_round_robin();
    logic [4:0] rr;
    logic [5:0] pc [2];
    logic [3:0] pd [2];
    int order [4];
    bit rearm [2];
    int issued, done, elat;
    logic [3:0] erd, rd;
    logic ee;
    do_reset();
    rr = 5'($urandom_range(0, 29));
    for (int c = 0; c < 2; c++) begin
      pc[c] = 6'((11 + 7 * c) % COLS); pd[c] = 4'($urandom);
      set_client(c, 1'b1, rr, pc[c], pd[c]);
      rearm[c] = 1'b0;
    end
    bus.req = 2'b11; issued = 2; done = 0;
    for (int cyc = 0; cyc < 200 && done < 4; cyc++) begin
      @(negedge CLOCK_50);
      for (int c = 0; c < 2; c++) begin
        if (rearm[c]) begin
          pc[c] = 6'((11 + 7 * issued) % COLS); pd[c] = 4'($urandom);
          set_client(c, 1'b1, rr, pc[c], pd[c]);
          issued++; bus.req[c] = 1'b1; rearm[c] = 1'b0;
        end else if (bus.ack[c]) begin
          order[done] = c;
          model_txn(c, 1'b1, rr, pc[c], pd[c], 0, elat, erd, ee);
          rd = (c == 1) ? bus.rdata[7:4] : bus.rdata[3:0];
          checks++; if (rd !== erd || bus.err !== 1'b0) begin errors++; $display("FAIL rr_data: got %0d err=%b want %0d", rd, bus.err, erd); end
          done++; bus.req[c] = 1'b0;
          if (issued < 4) rearm[c] = 1'b1;
        end
      end
    end
    bus.req = '0;
    checks++; if (done !== 4) begin errors++; $display("FAIL rr_timeout: got %0d acks want 4", done); end
    for (int i = 0; i < done; i++) begin
      checks++; if (order[i] !== i % 2) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % 2); end
    end
    @(negedge CLOCK_50);
    checks++; if (row_diffs(int'(rr)) !== 0) begin errors++; $display("FAIL rr_row: got %0d bad tiles want 0", row_diffs(int'(rr))); end
  endtask

  task automatic test_reset_abort();
    int seen;
    logic [4:0] r;
    r = 5'($urandom_range(0, 29));
    set_client(0, 1'b1, r, 6'd9, ~ref_t[r][9]);
    bus.req[0] = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1; bus.req = '0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLOCK_50);
      if (k == 1) reset = 1'b0;
      if (bus.ack !== 2'b00 || map_wren !== 1'b0) seen++;
    end
    exp_rd[0] = '0; exp_rd[1] = '0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_ack: got %0d ack/wren cycles want 0", seen); end
    checks++; if (row_diffs(int'(r)) !== 0 || bus.rdata !== 8'h00) begin errors++; $display("FAIL abort_state: got %0d bad tiles rdata=%h want 0/00", row_diffs(int'(r)), bus.rdata); end
  endtask

  initial begin
    bus.req = '0; bus.we = '0; bus.row = '0; bus.col = '0; bus.wdata = '0;
    @(negedge CLOCK_50);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) ref_t[r][c] = 4'($urandom_range(0, 3));
      load_row(r);
    end
    do_reset();
    test_reset();
    test_read();
    test_write();
    test_vga_preempt();
    test_out_of_range();
    test_random();
    test_round_robin();
    test_reset_abort();
    check_txn("post_abort", 1, 1'b0, 5'd3, 6'd5, 4'd0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
